// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: resolves NBITS bits MSB-first against a
// registered a<=b comparator with CMP_LAT cycles of latency, then pulses done with the code.
module sar_adc_ctrl #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_le,
  output logic [NBITS-1:0] dac_code,
  output logic             sample_hold,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  localparam int unsigned CntW = $clog2(CMP_LAT + 1);
  localparam int unsigned IdxW = $clog2(NBITS);

  typedef enum logic [1:0] {
    StIdle,
    StTrial,
    StDecide
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] bit_mask;
  logic [NBITS-1:0] kept_code;

  // dac_q always holds the resolved upper bits plus the bit under trial.
  assign bit_mask  = {{(NBITS-1){1'b0}}, 1'b1} << idx_q;
  assign kept_code = cmp_le ? (dac_q & ~bit_mask) : dac_q;

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    res_d   = res_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          dac_d   = {1'b1, {(NBITS-1){1'b0}}};
          idx_d   = IdxW'(NBITS - 1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StTrial;
        end
      end
      StTrial: begin
        if (cnt_q == CntW'(CMP_LAT - 1)) begin
          cnt_d   = CntW'(CMP_LAT);
          state_d = StDecide;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDecide: begin
        if (idx_q != '0) begin
          idx_d   = idx_q - IdxW'(1);
          dac_d   = kept_code | (bit_mask >> 1);
          cnt_d   = '0;
          state_d = StTrial;
        end else begin
          res_d   = kept_code;
          dac_d   = kept_code;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dac_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dac_code    = dac_q;
  assign result      = res_q;
  assign busy        = busy_q;
  assign sample_hold = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: two instances (4-bit/lat 1 and 8-bit/lat 3) driving behavioural
// registered comparators; expected codes go through per-instance scoreboard queues.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       cmp_a = 1'b0, cmp_b;
  logic [3:0] dac_a, result_a;
  logic [7:0] dac_b, result_b;
  logic       sh_a, busy_a, done_a, sh_b, busy_b, done_b;
  logic [4:0] s_a = '0;
  logic [8:0] s_b = '0;
  logic [2:0] pipe_b = '0;
  logic       flip_b = 1'b0;

  int total = 0;
  int bad = 0;
  int q_a[$];
  int q_b[$];

  always #5 clk = ~clk;

  sar_adc_ctrl #(.NBITS(4), .CMP_LAT(1)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .cmp_le     (cmp_a),
    .dac_code   (dac_a),
    .sample_hold(sh_a),
    .busy       (busy_a),
    .done       (done_a),
    .result     (result_a)
  );

  sar_adc_ctrl #(.NBITS(8), .CMP_LAT(3)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .cmp_le     (cmp_b),
    .dac_code   (dac_b),
    .sample_hold(sh_b),
    .busy       (busy_b),
    .done       (done_b),
    .result     (result_b)
  );

  // Ideal comparators: sample <= dac_code, registered over CMP_LAT stages.
  always @(posedge clk) cmp_a <= (s_a <= {1'b0, dac_a});
  always @(posedge clk) pipe_b <= {pipe_b[1:0], (s_b <= {1'b0, dac_b})};
  assign cmp_b = pipe_b[2] ^ flip_b;

  task automatic test_reset();
    start_a = 1'b1;
    start_b = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (dac_a !== 4'd0) begin bad++; $display("FAIL reset_dac_a got=%0d want=0", dac_a); end
    total++; if (result_a !== 4'd0) begin bad++; $display("FAIL reset_result_a got=%0d want=0", result_a); end
    total++; if ({busy_a, done_a, sh_a} !== 3'b000) begin
      bad++; $display("FAIL reset_flags_a got=%b want=000", {busy_a, done_a, sh_a});
    end
    total++; if ({busy_b, done_b, sh_b, dac_b, result_b} !== 19'd0) begin
      bad++; $display("FAIL reset_b got=%h want=0", {busy_b, done_b, sh_b, dac_b, result_b});
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%b want=0", busy_a); end
  endtask

  // Runs one conversion on instance A from IDLE and checks latency, result and done width.
  task automatic convert_a(input int s);
    int n;
    int exp;
    q_a.push_back((s == 0) ? 0 : s - 1);
    s_a     = 5'(s);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    total++; if (sh_a !== busy_a) begin bad++; $display("FAIL sh_eq_busy got=%b want=%b", sh_a, busy_a); end
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 8) begin bad++; $display("FAIL conv_a_latency s=%0d got=%0d want=8", s, n); end
    if (n < 40 && q_a.size() > 0) begin
      exp = q_a.pop_front();
      total++; if (result_a !== 4'(exp)) begin
        bad++; $display("FAIL conv_a_result s=%0d got=%0d want=%0d", s, result_a, exp);
      end
      total++; if (dac_a !== 4'(exp)) begin
        bad++; $display("FAIL conv_a_dac_hold s=%0d got=%0d want=%0d", s, dac_a, exp);
      end
    end
    @(negedge clk);
    total++; if ({done_a, busy_a} !== 2'b00) begin
      bad++; $display("FAIL conv_a_done_width s=%0d got=%b want=00", s, {done_a, busy_a});
    end
  endtask

  task automatic test_sequence();
    int seq[4] = '{8, 12, 10, 9};
    int exp;
    q_a.push_back(9);
    s_a     = 5'd10;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++; if (dac_a !== 4'(seq[b])) begin
        bad++; $display("FAIL seq_dac bit=%0d got=%0d want=%0d", b, dac_a, seq[b]);
      end
      total++; if ({busy_a, done_a} !== 2'b10) begin
        bad++; $display("FAIL seq_busy bit=%0d got=%b want=10", b, {busy_a, done_a});
      end
      @(negedge clk);
      @(negedge clk);
    end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL seq_done_at_8 got=%b want=1", done_a); end
    if (q_a.size() > 0) begin
      exp = q_a.pop_front();
      total++; if (result_a !== 4'(exp)) begin
        bad++; $display("FAIL seq_result got=%0d want=%0d", result_a, exp);
      end
    end
    @(negedge clk);
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL seq_done_width got=%b want=0", done_a); end
  endtask

  task automatic test_extremes();
    convert_a(0);
    convert_a(16);
    convert_a(1);
  endtask

  task automatic test_back_to_back();
    int n;
    int exp;
    q_a.push_back(4);
    s_a     = 5'd5;
    start_a = 1'b1;
    @(negedge clk);
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL b2b_first_latency got=%0d want=8", n); end
    if (n < 40 && q_a.size() > 0) begin
      exp = q_a.pop_front();
      total++; if (result_a !== 4'(exp)) begin
        bad++; $display("FAIL b2b_first_result got=%0d want=%0d", result_a, exp);
      end
    end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", busy_a); end
    s_a = 5'd12;
    q_a.push_back(11);
    @(negedge clk);
    total++; if ({busy_a, done_a, dac_a} !== 6'b10_1000) begin
      bad++; $display("FAIL b2b_restart got=%b want=101000", {busy_a, done_a, dac_a});
    end
    n = 0;
    while (done_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL b2b_second_latency got=%0d want=8", n); end
    if (n < 40 && q_a.size() > 0) begin
      exp = q_a.pop_front();
      total++; if (result_a !== 4'(exp)) begin
        bad++; $display("FAIL b2b_second_result got=%0d want=%0d", result_a, exp);
      end
    end
    start_a = 1'b0;
    @(negedge clk);
    total++; if ({busy_a, done_a} !== 2'b00) begin
      bad++; $display("FAIL b2b_no_third got=%b want=00", {busy_a, done_a});
    end
  endtask

  task automatic test_reset_mid();
    s_a     = 5'd3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if ({busy_a, done_a, sh_a, dac_a, result_a} !== 11'd0) begin
      bad++; $display("FAIL mid_reset got=%h want=0", {busy_a, done_a, sh_a, dac_a, result_a});
    end
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got=%b want=0", busy_a); end
    convert_a(7);
  endtask

  task automatic test_lat3();
    int k;
    int exp;
    q_b.push_back(199);
    s_b     = 9'd200;
    flip_b  = 1'b0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    total++; if (dac_b !== 8'd128) begin bad++; $display("FAIL lat3_first_dac got=%0d want=128", dac_b); end
    k = 0;
    // Noise on cmp_le in every cycle except DECIDE (cycle after edge S+k, k%4==3).
    while (done_b !== 1'b1 && k < 80) begin
      flip_b = (k % 4 == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    flip_b = 1'b0;
    total++; if (k !== 32) begin bad++; $display("FAIL lat3_latency got=%0d want=32", k); end
    if (k < 80 && q_b.size() > 0) begin
      exp = q_b.pop_front();
      total++; if (result_b !== 8'(exp)) begin
        bad++; $display("FAIL lat3_result got=%0d want=%0d", result_b, exp);
      end
      total++; if (dac_b !== 8'(exp)) begin
        bad++; $display("FAIL lat3_dac_hold got=%0d want=%0d", dac_b, exp);
      end
    end
    total++; if ({busy_b, sh_b} !== 2'b00) begin
      bad++; $display("FAIL lat3_busy_clear got=%b want=00", {busy_b, sh_b});
    end
    @(negedge clk);
    total++; if (done_b !== 1'b0) begin bad++; $display("FAIL lat3_done_width got=%b want=0", done_b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      convert_a(int'($urandom_range(0, 16)));
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_lat3();
    test_random();
    total++; if (q_a.size() + q_b.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d want=0", q_a.size() + q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
